rate_meter: RTL

RATE_METER -- requirements
Module: rate_meter

---
 rtl/rate_meter.sv | 94 +++++++++
 1 files changed

// File: rtl/rate_meter.sv
// Windowed event-rate meter: counts i_event strobes over back-to-back windows of
// i_window cycles and publishes a saturated count plus overflow flag at each window end.
module rate_meter #(
    parameter int CNTWIDTH = 16,
    parameter int WINWIDTH = 24
) (
    input  logic                i_clk,
    input  logic                i_reset_l,
    input  logic                i_enable,
    input  logic                i_event,
    input  logic [WINWIDTH-1:0] i_window,
    output logic [CNTWIDTH-1:0] o_rate,
    output logic                o_overflow,
    output logic                o_update,
    output logic                o_busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

    logic [0:0]          state;
    logic [WINWIDTH-1:0] win_cnt;
    logic [WINWIDTH-1:0] win_load;
    logic [CNTWIDTH-1:0] evt_cnt;
    logic [CNTWIDTH-1:0] evt_next;
    logic                sat;
    logic                sat_hit;
    logic                sat_next;

    // Returns {saturation_hit, next_count}; the count sticks at CNT_MAX.
    function automatic logic [CNTWIDTH:0] sat_inc(input logic [CNTWIDTH-1:0] cnt,
                                                  input logic inc);
        if (!inc) begin
            return {1'b0, cnt};
        end
        if (cnt == CNT_MAX) begin
            return {1'b1, cnt};
        end
        return {1'b0, cnt + CNTWIDTH'(1)};
    endfunction

    // A zero-length window behaves as a single-cycle window, so no underflow here.
    assign win_load = (i_window == '0) ? '0 : i_window - WINWIDTH'(1);

    assign {sat_hit, evt_next} = sat_inc(evt_cnt, i_event);
    assign sat_next = sat | sat_hit;

    assign o_busy = (state == RUN);

    always_ff @(posedge i_clk or negedge i_reset_l) begin
        if (!i_reset_l) begin
            state      <= IDLE;
            win_cnt    <= '0;
            evt_cnt    <= '0;
            sat        <= 1'b0;
            o_rate     <= '0;
            o_overflow <= 1'b0;
            o_update   <= 1'b0;
        end else begin
            o_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_enable) begin
                        state   <= RUN;
                        win_cnt <= win_load;
                    end
                end
                RUN: begin
                    if (!i_enable) begin
                        // Abort takes priority over a coincident window end.
                        state   <= IDLE;
                        win_cnt <= '0;
                        evt_cnt <= '0;
                        sat     <= 1'b0;
                    end else if (win_cnt == '0) begin
                        o_rate     <= evt_next;
                        o_overflow <= sat_next;
                        o_update   <= 1'b1;
                        evt_cnt    <= '0;
                        sat        <= 1'b0;
                        win_cnt    <= win_load;
                    end else begin
                        win_cnt <= win_cnt - WINWIDTH'(1);
                        evt_cnt <= evt_next;
                        sat     <= sat_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
